// File: rtl/clk_div_bank_if.sv
// Control/status bundle for clk_div_bank; the STROBE vector exists only when
// CLK_DIV_BANK_STROBE_EN is defined.
interface clk_div_bank_if #(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 8
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en;
    logic              div_load;
    logic [SEL_W-1:0]  div_sel;
    logic [DIV_W-1:0]  div_val;
    logic              sync;
    logic [NUM_CH-1:0] clk_div_out;
    logic [NUM_CH-1:0] pending;
    logic              div_err;
`ifdef CLK_DIV_BANK_STROBE_EN
    logic [NUM_CH-1:0] strobe;

    modport master (output en, div_load, div_sel, div_val, sync,
                    input  clk_div_out, pending, div_err, strobe);
    modport slave  (input  en, div_load, div_sel, div_val, sync,
                    output clk_div_out, pending, div_err, strobe);
`else
    modport master (output en, div_load, div_sel, div_val, sync,
                    input  clk_div_out, pending, div_err);
    modport slave  (input  en, div_load, div_sel, div_val, sync,
                    output clk_div_out, pending, div_err);
`endif
endinterface

// File: rtl/clk_div_bank.sv
// Bank of runtime-programmable clock dividers with shadowed, glitch-free ratio
// changes and global realign. Optional phase-0 strobe: CLK_DIV_BANK_STROBE_EN.
module clk_div_ch #(
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             sync_i,
    input  logic [DIV_W-1:0] val_i,
    output logic             out_o,
`ifdef CLK_DIV_BANK_STROBE_EN
    output logic             strb_o,
`endif
    output logic             pend_o
);
    localparam logic [DIV_W-1:0] ONE   = 1;
    localparam logic [DIV_W:0]   ONE_X = 1;

    logic [DIV_W-1:0] div_q, div_d, shd_q, shd_d, ph_q, ph_d;
    logic             pend_q, pend_d, run_q, out_q, out_d;
    logic [DIV_W:0]   half;
`ifdef CLK_DIV_BANK_STROBE_EN
    logic             strb_q, strb_d;
`endif

    always_comb begin
        div_d  = div_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        ph_d   = ph_q;
        if (!en_i) begin
            ph_d = '0;
            if (pend_q) begin
                div_d  = shd_q;
                pend_d = 1'b0;
            end
            if (load_i) begin
                shd_d  = val_i;
                pend_d = 1'b1;
            end
        end else if (sync_i) begin
            // A load coinciding with SYNC goes straight to the active divisor.
            ph_d = '0;
            if (load_i) begin
                div_d  = val_i;
                shd_d  = val_i;
                pend_d = 1'b0;
            end else if (pend_q) begin
                div_d  = shd_q;
                pend_d = 1'b0;
            end
        end else begin
            // Start edge and wrap edge both open a fresh period under the shadow.
            if (!run_q || (ph_q == div_q - ONE)) begin
                ph_d = '0;
                if (pend_q) begin
                    div_d  = shd_q;
                    pend_d = 1'b0;
                end
            end else begin
                ph_d = ph_q + ONE;
            end
            if (load_i) begin
                shd_d  = val_i;
                pend_d = 1'b1;
            end
        end
        half  = ({1'b0, div_d} + ONE_X) >> 1;
        out_d = en_i && ({1'b0, ph_d} < half);
`ifdef CLK_DIV_BANK_STROBE_EN
        strb_d = en_i && (ph_d == '0);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= DIV_W'(RESET_DIV);
            shd_q  <= DIV_W'(RESET_DIV);
            pend_q <= 1'b0;
            ph_q   <= '0;
            run_q  <= 1'b0;
            out_q  <= 1'b0;
`ifdef CLK_DIV_BANK_STROBE_EN
            strb_q <= 1'b0;
`endif
        end else begin
            div_q  <= div_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            ph_q   <= ph_d;
            run_q  <= en_i;
            out_q  <= out_d;
`ifdef CLK_DIV_BANK_STROBE_EN
            strb_q <= strb_d;
`endif
        end
    end

    assign out_o  = out_q;
    assign pend_o = pend_q;
`ifdef CLK_DIV_BANK_STROBE_EN
    assign strb_o = strb_q;
`endif
endmodule

module clk_div_bank #(
    parameter int NUM_CH    = 3,
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    clk_div_bank_if.slave  bus
);
    logic              load_ok;
    logic              err_q;
    logic [NUM_CH-1:0] out_w, pend_w;
`ifdef CLK_DIV_BANK_STROBE_EN
    logic [NUM_CH-1:0] strb_w;
`endif

    assign load_ok = bus.div_load && (bus.div_val != '0) && (int'(bus.div_sel) < NUM_CH);

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= bus.div_load && !load_ok;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_ch #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (bus.en[c]),
            .load_i (load_ok && (int'(bus.div_sel) == c)),
            .sync_i (bus.sync),
            .val_i  (bus.div_val),
            .out_o  (out_w[c]),
`ifdef CLK_DIV_BANK_STROBE_EN
            .strb_o (strb_w[c]),
`endif
            .pend_o (pend_w[c])
        );
    end

    assign bus.clk_div_out = out_w;
    assign bus.pending     = pend_w;
    assign bus.div_err     = err_q;
`ifdef CLK_DIV_BANK_STROBE_EN
    assign bus.strobe      = strb_w;
`endif
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed plus randomized bench for clk_div_bank against a per-channel
// period/phase reference model.
module tb_clk_div_bank;
    localparam int NUM_CH = 3, DIV_W = 8, RESET_DIV = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clk_div_bank_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus();
    clk_div_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0, passed = 0;
    int mD[NUM_CH], mS[NUM_CH], mPh[NUM_CH];
    bit mP[NUM_CH], mRun[NUM_CH];
    bit mErr;
    int hi;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    // State after one edge, from the documented channel rules.
    task automatic model();
        int sel, val;
        bit ok, ld;
        sel = int'(bus.div_sel);
        val = int'(bus.div_val);
        ok  = bus.div_load && val != 0 && sel < NUM_CH;
        if (rst) begin
            mErr = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                mD[c] = RESET_DIV; mS[c] = RESET_DIV; mP[c] = 0; mPh[c] = 0; mRun[c] = 0;
            end
            return;
        end
        mErr = bus.div_load && !ok;
        for (int c = 0; c < NUM_CH; c++) begin
            ld = ok && sel == c;
            if (!bus.en[c]) begin
                mPh[c] = 0; mRun[c] = 0;
                if (mP[c]) begin mD[c] = mS[c]; mP[c] = 0; end
                if (ld) begin mS[c] = val; mP[c] = 1; end
            end else if (bus.sync) begin
                mPh[c] = 0; mRun[c] = 1;
                if (ld) begin mD[c] = val; mS[c] = val; mP[c] = 0; end
                else if (mP[c]) begin mD[c] = mS[c]; mP[c] = 0; end
            end else begin
                if (!mRun[c] || mPh[c] == mD[c] - 1) begin
                    mPh[c] = 0;
                    if (mP[c]) begin mD[c] = mS[c]; mP[c] = 0; end
                end else mPh[c]++;
                if (ld) begin mS[c] = val; mP[c] = 1; end
                mRun[c] = 1;
            end
        end
    endtask

    task automatic compare();
        logic [NUM_CH-1:0] eo, ep, es;
        for (int c = 0; c < NUM_CH; c++) begin
            eo[c] = mRun[c] && (mPh[c] < (mD[c] + 1) / 2);
            ep[c] = mP[c];
            es[c] = mRun[c] && mPh[c] == 0;
        end
        chk("clk_div_out", 32'(bus.clk_div_out), 32'(eo));
        chk("pending", 32'(bus.pending), 32'(ep));
        chk("div_err", 32'(bus.div_err), 32'(mErr));
`ifdef CLK_DIV_BANK_STROBE_EN
        chk("strobe", 32'(bus.strobe), 32'(es));
`else
        if (es === 'x) chk("strobe_x", 32'(es), 32'(0));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        #1;
        compare();
    endtask

    task automatic load(int sel, int val);
        bus.div_load = 1'b1;
        bus.div_sel  = 2'(sel);
        bus.div_val  = 8'(val);
        tick();
        bus.div_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.en = '0; bus.div_load = 1'b0; bus.div_sel = '0; bus.div_val = '0; bus.sync = 1'b0;
        tick(); tick();
        chk("rst_out", 32'(bus.clk_div_out), 32'd0);
        chk("rst_pend", 32'(bus.pending), 32'd0);
        chk("rst_err", 32'(bus.div_err), 32'd0);

        // multi-ratio run: 2/3/4, phase-locked every 12 cycles
        rst = 1'b0;
        load(0, 2); load(1, 3); load(2, 4);
        chk("idle_pend2", 32'(bus.pending[2]), 32'd1);
        bus.en = 3'b111;
        begin
            int h0 = 0, h1 = 0, h2 = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                h0 += int'(bus.clk_div_out[0]);
                h1 += int'(bus.clk_div_out[1]);
                h2 += int'(bus.clk_div_out[2]);
            end
            chk("hi_d2", 32'(h0), 32'd6);
            chk("hi_d3", 32'(h1), 32'd8);
            chk("hi_d4", 32'(h2), 32'd6);
        end
        tick();
        chk("lock12", 32'(bus.clk_div_out), 32'b111);

        // glitch-free change on ch1: 3 -> 5
        load(1, 5);
        chk("pend1_a", 32'(bus.pending[1]), 32'd1);
        tick();
        chk("pend1_b", 32'(bus.pending[1]), 32'd1);
        tick();
        chk("pend1_c", 32'(bus.pending[1]), 32'd0);
        hi = int'(bus.clk_div_out[1]);
        for (int i = 0; i < 4; i++) begin tick(); hi += int'(bus.clk_div_out[1]); end
        chk("hi_d5", 32'(hi), 32'd3);

        // rejected loads
        load(1, 0);
        chk("err_val0", 32'(bus.div_err), 32'd1);
        load(3, 7);
        chk("err_sel3", 32'(bus.div_err), 32'd1);
        chk("err_nopend", 32'(bus.pending), 32'd0);
        tick();
        chk("err_clr", 32'(bus.div_err), 32'd0);

        // realign with bypass load ch2=6
        tick();
        bus.sync = 1'b1;
        load(2, 6);
        bus.sync = 1'b0;
        chk("sync_out", 32'(bus.clk_div_out), 32'b111);
        chk("sync_pend2", 32'(bus.pending[2]), 32'd0);
        hi = int'(bus.clk_div_out[2]);
        for (int i = 0; i < 5; i++) begin tick(); hi += int'(bus.clk_div_out[2]); end
        chk("hi_d6", 32'(hi), 32'd3);
        tick();
        chk("d6_wrap", 32'(bus.clk_div_out[2]), 32'd1);

        // ratio extremes: 1 and 255
        bus.sync = 1'b1; load(0, 1); bus.sync = 1'b0;
        hi = 0;
        for (int i = 0; i < 5; i++) begin tick(); hi += int'(bus.clk_div_out[0]); end
        chk("d1_const", 32'(hi), 32'd5);
        bus.sync = 1'b1; load(0, 255); bus.sync = 1'b0;
        hi = int'(bus.clk_div_out[0]);
        for (int i = 0; i < 254; i++) begin tick(); hi += int'(bus.clk_div_out[0]); end
        chk("hi_d255", 32'(hi), 32'd128);
        tick();
        chk("d255_wrap", 32'(bus.clk_div_out[0]), 32'd1);

        // reset during ch0 high phase
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid", 32'(bus.clk_div_out), 32'd0);
        tick();
        chk("re_en_hi", 32'(bus.clk_div_out), 32'b111);
        tick();
        chk("re_en_lo", 32'(bus.clk_div_out), 32'b000);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.en = 3'($urandom);
            bus.div_load = ($urandom_range(0, 3) == 0);
            bus.div_sel  = 2'($urandom_range(0, 3));
            bus.div_val  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(0, 6));
            bus.sync     = ($urandom_range(0, 29) == 0);
            rst          = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
